// File: rtl/mpb_mem_responder_pkg.sv
// Shared types and constants for the MPB memory responder.
// Holds the FSM state enum, the LFSR seed and tap mask, the counter width,
// and a saturating increment helper for the transaction counters.
package mpb_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mpb_mem_resp_state_t;

  localparam logic [7:0] MPB_MEM_RESP_LFSR_SEED = 8'hA5;
  localparam logic [7:0] MPB_MEM_RESP_LFSR_TAPS = 8'hB8;
  localparam int         MPB_MEM_RESP_CNT_W     = 16;

  function automatic logic [MPB_MEM_RESP_CNT_W-1:0] sat_inc(
    input logic [MPB_MEM_RESP_CNT_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mpb_mem_responder_if.sv
// MPB request/response bundle between a bus master and a memory target.
// The master drives vld/wr/addr/wdata; the target answers with rdy/rdata.
interface mpb_mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  vld;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rdy;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output vld, wr, addr, wdata,
    input  rdy, rdata
  );

  modport slave (
    input  vld, wr, addr, wdata,
    output rdy, rdata
  );

endinterface

// File: rtl/mpb_mem_responder_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to draw random wait states.
// Reloads the fixed seed on reset and steps once per cycle while en is high.
module mpb_mem_responder_lfsr
  import mpb_mem_responder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] state
);

  // Shift left, feeding the parity of the tapped bits back into bit 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MPB_MEM_RESP_LFSR_SEED;
    end else if (en) begin
      state <= {state[6:0], ^(state & MPB_MEM_RESP_LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/mpb_mem_responder.sv
// MPB memory target: flop-based word memory answering one request at a time
// after a number of wait states, with saturating transfer counters and a
// sticky flag for a master that drops vld before rdy.
// Optional feature macro: MPB_MEM_RESPONDER_RANDOM_WAIT_EN draws the wait
// count from an LFSR on every accepted request instead of using WAIT_CYCLES.
module mpb_mem_responder
  import mpb_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  mpb_mem_responder_if.slave            bus,
  output logic [MPB_MEM_RESP_CNT_W-1:0] wr_cnt,
  output logic [MPB_MEM_RESP_CNT_W-1:0] rd_cnt,
  output logic                          protocol_err
);

  localparam int IDX_W = $clog2(DEPTH);

  mpb_mem_resp_state_t   state, state_next;
  logic [3:0]            wait_cnt, wait_cnt_next;
  logic [3:0]            wait_draw;
  logic                  do_resp;
  logic                  err_set;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [IDX_W-1:0]      idx;
  logic                  addr_unused;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign req_addr    = bus.addr;
  assign idx         = req_addr[2 +: IDX_W];
  assign addr_unused = ^{req_addr[ADDR_WIDTH-1:IDX_W+2], req_addr[1:0]};

`ifdef MPB_MEM_RESPONDER_RANDOM_WAIT_EN
  logic [7:0] lfsr_state;
  logic       accept;

  assign accept    = (state == IDLE) && bus.vld;
  assign wait_draw = 4'(lfsr_state % 8'(WAIT_CYCLES + 1));

  mpb_mem_responder_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .state (lfsr_state)
  );
`else
  assign wait_draw = 4'(WAIT_CYCLES);
`endif

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state logic: accept, count down wait states, respond, or abort
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    do_resp       = 1'b0;
    err_set       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.vld) begin
          wait_cnt_next = wait_draw;
          state_next    = (wait_draw == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!bus.vld) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state_next = RESP;
        end
      end
      RESP: begin
        do_resp    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory access, response strobe, counters and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rdy      <= 1'b0;
      bus.rdata    <= '0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      protocol_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      bus.rdy <= do_resp;
      if (err_set) protocol_err <= 1'b1;
      if (do_resp) begin
        if (bus.wr) begin
          mem[idx]  <= bus.wdata;
          bus.rdata <= '0;
          wr_cnt    <= sat_inc(wr_cnt);
        end else begin
          bus.rdata <= mem[idx];
          rd_cnt    <= sat_inc(rd_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_mpb_mem_responder.sv
// Scoreboard bench for mpb_mem_responder: stimulus pushes expected responses
// computed from an address-indexed reference memory, a monitor pops and
// compares them whenever rdy is seen.
module tb_mpb_mem_responder;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;
  localparam int WC    = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;
  logic        protocol_err;

  mpb_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mpb_mem_responder #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .wr_cnt       (wr_cnt),
    .rd_cnt       (rd_cnt),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [31:0] rdata;
    int          rdy_cycle;
    int          wr_cnt;
    int          rd_cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem[int];
  int          m_wr   = 0;
  int          m_rd   = 0;
  int          m_lfsr = 'hA5;
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int next_lfsr(input int s);
    int fb;
    fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
    return ((s << 1) & 255) | fb;
  endfunction

  function automatic int draw_wait();
`ifdef MPB_MEM_RESPONDER_RANDOM_WAIT_EN
    int w;
    w = m_lfsr % (WC + 1);
    m_lfsr = next_lfsr(m_lfsr);
    return w;
`else
    return WC;
`endif
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
  endfunction

  function automatic int sat16(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  // Issue one transfer, record its expected response, wait for rdy
  task automatic applyStimulus(input bit is_wr, input logic [31:0] a,
                               input logic [31:0] d);
    exp_t e;
    int   idx;
    int   w;
    int   waited;
    @(negedge clk);
    bus.vld   = 1'b1;
    bus.wr    = is_wr;
    bus.addr  = a;
    bus.wdata = d;
    idx = int'(a >> 2) % DEPTH;
    w   = draw_wait();
    if (is_wr) begin
      model_mem[idx] = d;
      m_wr    = sat16(m_wr);
      e.rdata = 32'h0;
    end else begin
      e.rdata = model_read(idx);
      m_rd    = sat16(m_rd);
    end
    e.rdy_cycle = cycle + w + 2;
    e.wr_cnt    = m_wr;
    e.rd_cnt    = m_rd;
    exp_q.push_back(e);
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (bus.rdy !== 1'b1 && waited < 40);
    if (bus.rdy !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL rdy_timeout: no rdy after %0d cycles, required rdy", waited);
    end
  endtask

  task automatic idleCycles(input int n);
    @(negedge clk);
    bus.vld = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic checkResetValues();
    checkOutput("reset_rdy", 32'(bus.rdy), 32'h0);
    checkOutput("reset_rdata", bus.rdata, 32'h0);
    checkOutput("reset_wr_cnt", 32'(wr_cnt), 32'h0);
    checkOutput("reset_rd_cnt", 32'(rd_cnt), 32'h0);
    checkOutput("reset_protocol_err", 32'(protocol_err), 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom();
    return (r & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  // Monitor: every rdy must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.rdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rdy: rdy=1 at cycle %0d, required no response", cycle);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rdata", bus.rdata, e.rdata);
          checkOutput("rdy_cycle", 32'(cycle), 32'(e.rdy_cycle));
          checkOutput("wr_cnt", 32'(wr_cnt), 32'(e.wr_cnt));
          checkOutput("rd_cnt", 32'(rd_cnt), 32'(e.rd_cnt));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.vld   = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkResetValues();

    $display("[TB] write/read 0x10");
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h10, 32'h0);
    idleCycles(2);

    $display("[TB] aliasing");
    applyStimulus(1'b1, 32'h0000_0004, 32'h11);
    applyStimulus(1'b0, 32'h0000_0404, 32'h0);
    idleCycles(2);

    $display("[TB] back-to-back reads");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, rand_addr(), 32'h0);
    idleCycles(2);

`ifndef MPB_MEM_RESPONDER_RANDOM_WAIT_EN
    $display("[TB] vld dropped during wait");
    @(negedge clk);
    bus.vld   = 1'b1;
    bus.wr    = 1'b1;
    bus.addr  = 32'h10;
    bus.wdata = 32'h5555_AAAA;
    @(negedge clk);
    @(negedge clk);
    bus.vld = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort_protocol_err", 32'(protocol_err), 32'h1);
    checkOutput("abort_wr_cnt", 32'(wr_cnt), 32'(m_wr));
    checkOutput("abort_rd_cnt", 32'(rd_cnt), 32'(m_rd));
    applyStimulus(1'b0, 32'h10, 32'h0);
    idleCycles(2);
    checkOutput("sticky_protocol_err", 32'(protocol_err), 32'h1);

    $display("[TB] reset during wait");
    @(negedge clk);
    bus.vld   = 1'b1;
    bus.wr    = 1'b1;
    bus.addr  = 32'h30;
    bus.wdata = 32'h1234_5678;
    @(negedge clk);
    reset   = 1'b1;
    bus.vld = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_mem.delete();
    m_wr   = 0;
    m_rd   = 0;
    m_lfsr = 'hA5;
    checkResetValues();
    applyStimulus(1'b0, 32'h30, 32'h0);
    applyStimulus(1'b0, 32'h10, 32'h0);
    idleCycles(2);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 100; i++) begin
      int gap;
      applyStimulus(1'($urandom_range(0, 1)), rand_addr(), $urandom());
      gap = $urandom_range(0, 2);
      if (gap > 0) idleCycles(gap);
    end
    idleCycles(6);

    checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
